// File: rtl/inmux_sched.sv
// inmux_sched: round-robin / fixed-priority burst scheduler sharing one inmux lane between N sources
module inmux_sched #(
  parameter int N = 4,
  parameter int SELW = 2,
  parameter int BURSTW = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      src_req,
  input  logic [N-1:0]      cfg_mask,
  input  logic              cfg_prio_en,
  input  logic [BURSTW-1:0] cfg_burst,
  output logic [SELW-1:0]   sel,
  output logic              t_c_req,
  input  logic              t_c_ack,
  output logic              grant_idx_valid,
  output logic              burst_done,
  output logic              grant_abort,
  output logic [BURSTW-1:0] xfer_left
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_nx;
  logic [N-1:0] elig;
  logic [SELW-1:0] last_grant, last_nx, sel_nx, lo_w, hi_w, win;
  logic [BURSTW-1:0] xfer_nx;
  logic hi_f, xfer, done_nx, abort_nx;
  assign elig = src_req & cfg_mask;
  assign xfer = t_c_req & t_c_ack;
  assign t_c_req = state == GRANT;
  assign grant_idx_valid = state == GRANT;
  always_comb begin
    lo_w = '0;
    hi_w = '0;
    hi_f = 1'b0;
    for (int j = N - 1; j >= 0; j--) begin
      if (elig[j]) lo_w = SELW'(j);
      if (elig[j] && SELW'(j) > last_grant) begin
        hi_w = SELW'(j);
        hi_f = 1'b1;
      end
    end
    win = cfg_prio_en ? lo_w : (hi_f ? hi_w : lo_w);
  end
  always_comb begin
    state_nx = state;
    sel_nx = sel;
    last_nx = last_grant;
    xfer_nx = xfer_left;
    done_nx = 1'b0;
    abort_nx = 1'b0;
    if (state == IDLE) begin
      if (|elig) begin
        sel_nx = win;
        last_nx = win;
        xfer_nx = (cfg_burst == '0) ? BURSTW'(1) : cfg_burst;
        state_nx = GRANT;
      end
    end else if (xfer && xfer_left == BURSTW'(1)) begin
      done_nx = 1'b1;
      xfer_nx = '0;
      state_nx = IDLE;
    end else if (xfer) begin
      xfer_nx = xfer_left - BURSTW'(1);
    end else if (!elig[sel]) begin
      abort_nx = 1'b1;
      xfer_nx = '0;
      state_nx = IDLE;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sel <= '0;
      last_grant <= SELW'(N - 1);
      xfer_left <= '0;
      burst_done <= 1'b0;
      grant_abort <= 1'b0;
    end else begin
      state <= state_nx;
      sel <= sel_nx;
      last_grant <= last_nx;
      xfer_left <= xfer_nx;
      burst_done <= done_nx;
      grant_abort <= abort_nx;
    end
  end
endmodule

// File: tb/tb_inmux_sched.sv
// tb_inmux_sched: table-driven directed checks of inmux_sched arbitration, bursts and aborts
module tb_inmux_sched;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] src_req = '0;
  logic [3:0] cfg_mask = 4'b1111;
  logic cfg_prio_en = 1'b0;
  logic [3:0] cfg_burst = '0;
  logic t_c_ack = 1'b0;
  logic [1:0] sel;
  logic t_c_req, grant_idx_valid, burst_done, grant_abort;
  logic [3:0] xfer_left;
  int ncmp = 0;
  int nfail = 0;
  typedef struct {
    logic [3:0] req;
    logic [3:0] mask;
    logic prio;
    logic [3:0] burst;
    logic ack;
    logic [1:0] sel;
    logic rq;
    logic done;
    logic ab;
    logic [3:0] xl;
  } vec_t;
  vec_t vecs[$];
  inmux_sched #(.N(4), .SELW(2), .BURSTW(4)) dut (
    .clk(clk), .reset(reset), .src_req(src_req), .cfg_mask(cfg_mask),
    .cfg_prio_en(cfg_prio_en), .cfg_burst(cfg_burst), .sel(sel), .t_c_req(t_c_req),
    .t_c_ack(t_c_ack), .grant_idx_valid(grant_idx_valid), .burst_done(burst_done),
    .grant_abort(grant_abort), .xfer_left(xfer_left)
  );
  always #5 clk = ~clk;
  function automatic vec_t v(input logic [3:0] req, input logic [3:0] mask, input logic prio,
                             input logic [3:0] burst, input logic ack, input logic [1:0] s,
                             input logic rq, input logic done, input logic ab, input logic [3:0] xl);
    vec_t r;
    r = '{req, mask, prio, burst, ack, s, rq, done, ab, xl};
    return r;
  endfunction
  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s row %0d: got %0h want %0h", name, row, act, exp);
    end
  endtask
  task automatic chk_all(input int row, input logic [1:0] s, input logic rq, input logic done,
                         input logic ab, input logic [3:0] xl);
    chk("sel", row, 32'(sel), 32'(s));
    chk("t_c_req", row, 32'(t_c_req), 32'(rq));
    chk("grant_idx_valid", row, 32'(grant_idx_valid), 32'(rq));
    chk("burst_done", row, 32'(burst_done), 32'(done));
    chk("grant_abort", row, 32'(grant_abort), 32'(ab));
    chk("xfer_left", row, 32'(xfer_left), 32'(xl));
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    // round-robin, burst 1, ack always high
    vecs.push_back(v(4'b1111, 4'b1111, 0, 1, 1, 0, 1, 0, 0, 1));
    vecs.push_back(v(4'b1111, 4'b1111, 0, 1, 1, 0, 0, 1, 0, 0));
    vecs.push_back(v(4'b1111, 4'b1111, 0, 1, 1, 1, 1, 0, 0, 1));
    vecs.push_back(v(4'b1111, 4'b1111, 0, 1, 1, 1, 0, 1, 0, 0));
    vecs.push_back(v(4'b1111, 4'b1111, 0, 1, 1, 2, 1, 0, 0, 1));
    vecs.push_back(v(4'b1111, 4'b1111, 0, 1, 1, 2, 0, 1, 0, 0));
    vecs.push_back(v(4'b1111, 4'b1111, 0, 1, 1, 3, 1, 0, 0, 1));
    vecs.push_back(v(4'b1111, 4'b1111, 0, 1, 1, 3, 0, 1, 0, 0));
    vecs.push_back(v(4'b1111, 4'b1111, 0, 1, 1, 0, 1, 0, 0, 1));
    vecs.push_back(v(4'b1111, 4'b1111, 0, 1, 1, 0, 0, 1, 0, 0));
    // burst hold with ack toggling
    vecs.push_back(v(4'b0110, 4'b1111, 0, 3, 0, 1, 1, 0, 0, 3));
    vecs.push_back(v(4'b0110, 4'b1111, 0, 3, 1, 1, 1, 0, 0, 2));
    vecs.push_back(v(4'b0110, 4'b1111, 0, 3, 0, 1, 1, 0, 0, 2));
    vecs.push_back(v(4'b0110, 4'b1111, 0, 3, 1, 1, 1, 0, 0, 1));
    vecs.push_back(v(4'b0110, 4'b1111, 0, 3, 0, 1, 1, 0, 0, 1));
    vecs.push_back(v(4'b0110, 4'b1111, 0, 3, 1, 1, 0, 1, 0, 0));
    vecs.push_back(v(4'b0110, 4'b1111, 0, 3, 0, 2, 1, 0, 0, 3));
    vecs.push_back(v(4'b0000, 4'b1111, 0, 3, 0, 2, 0, 0, 1, 0));
    vecs.push_back(v(4'b0000, 4'b1111, 0, 3, 0, 2, 0, 0, 0, 0));
    // early release, then next winner 3; transfer on req drop still counts
    vecs.push_back(v(4'b0100, 4'b1111, 0, 4, 0, 2, 1, 0, 0, 4));
    vecs.push_back(v(4'b0100, 4'b1111, 0, 4, 1, 2, 1, 0, 0, 3));
    vecs.push_back(v(4'b1000, 4'b1111, 0, 4, 0, 2, 0, 0, 1, 0));
    vecs.push_back(v(4'b1000, 4'b1111, 0, 4, 0, 3, 1, 0, 0, 4));
    vecs.push_back(v(4'b0000, 4'b1111, 0, 4, 1, 3, 1, 0, 0, 3));
    vecs.push_back(v(4'b0000, 4'b1111, 0, 4, 0, 3, 0, 0, 1, 0));
    vecs.push_back(v(4'b0000, 4'b1111, 0, 4, 0, 3, 0, 0, 0, 0));
    // fixed priority, then mask out index 1
    vecs.push_back(v(4'b1010, 4'b1111, 1, 1, 1, 1, 1, 0, 0, 1));
    vecs.push_back(v(4'b1010, 4'b1111, 1, 1, 1, 1, 0, 1, 0, 0));
    vecs.push_back(v(4'b1010, 4'b1111, 1, 1, 1, 1, 1, 0, 0, 1));
    vecs.push_back(v(4'b1010, 4'b1111, 1, 1, 1, 1, 0, 1, 0, 0));
    vecs.push_back(v(4'b1010, 4'b1101, 1, 1, 1, 3, 1, 0, 0, 1));
    vecs.push_back(v(4'b1010, 4'b1101, 1, 1, 1, 3, 0, 1, 0, 0));
    // live mask clear mid-grant aborts
    vecs.push_back(v(4'b1010, 4'b1111, 1, 2, 0, 1, 1, 0, 0, 2));
    vecs.push_back(v(4'b1010, 4'b1101, 1, 2, 0, 1, 0, 0, 1, 0));
    vecs.push_back(v(4'b1010, 4'b1101, 1, 2, 0, 3, 1, 0, 0, 2));
    vecs.push_back(v(4'b0000, 4'b1101, 1, 2, 0, 3, 0, 0, 1, 0));
    vecs.push_back(v(4'b0000, 4'b1111, 0, 2, 0, 3, 0, 0, 0, 0));
    // burst 0 acts as 1; burst change mid-grant applies next grant
    vecs.push_back(v(4'b0001, 4'b1111, 0, 0, 1, 0, 1, 0, 0, 1));
    vecs.push_back(v(4'b0001, 4'b1111, 0, 0, 1, 0, 0, 1, 0, 0));
    vecs.push_back(v(4'b0001, 4'b1111, 0, 2, 0, 0, 1, 0, 0, 2));
    vecs.push_back(v(4'b0001, 4'b1111, 0, 5, 1, 0, 1, 0, 0, 1));
    vecs.push_back(v(4'b0001, 4'b1111, 0, 5, 1, 0, 0, 1, 0, 0));
    vecs.push_back(v(4'b0001, 4'b1111, 0, 5, 0, 0, 1, 0, 0, 5));
    vecs.push_back(v(4'b0000, 4'b1111, 0, 5, 0, 0, 0, 0, 1, 0));
    vecs.push_back(v(4'b0000, 4'b1111, 0, 5, 0, 0, 0, 0, 0, 0));
    #3;
    chk_all(-1, 0, 0, 0, 0, 0);
    tick();
    chk_all(-2, 0, 0, 0, 0, 0);
    reset = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      src_req = vecs[i].req;
      cfg_mask = vecs[i].mask;
      cfg_prio_en = vecs[i].prio;
      cfg_burst = vecs[i].burst;
      t_c_ack = vecs[i].ack;
      tick();
      chk_all(i, vecs[i].sel, vecs[i].rq, vecs[i].done, vecs[i].ab, vecs[i].xl);
    end
    // asynchronous reset in the middle of a burst
    src_req = 4'b0100;
    cfg_mask = 4'b1111;
    cfg_prio_en = 1'b0;
    cfg_burst = 4'd3;
    t_c_ack = 1'b0;
    tick();
    chk_all(100, 2, 1, 0, 0, 3);
    t_c_ack = 1'b1;
    tick();
    chk_all(101, 2, 1, 0, 0, 2);
    #2;
    reset = 1'b1;
    #1;
    chk_all(102, 0, 0, 0, 0, 0);
    #2;
    reset = 1'b0;
    src_req = 4'b1001;
    t_c_ack = 1'b0;
    tick();
    chk_all(103, 0, 1, 0, 0, 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
